mu0_run_monitor: RTL
====================

# mu0_run_monitor

Synthesizable run-control and halt monitor for the MU0 processor family, parametrised in data width, opcode field and halt opcode. It sits beside an MU0 core, watches the instruction register at every fetch, and reports halt (STP), watchdog timeout, cycle and instruction counts, and the PC/ACC captured at halt. Benches and FPGA builds use it as the single end-of-run detector instead of ad-hoc polling.

## Interface
- MAXWIDTH, 16, width of pc, ir, acc
- OPW, 4, opcode field width; opcode = ir[MAXWIDTH-1:MAXWIDTH-OPW]
- STP, 4'b0111, halt opcode value (OPW bits)
- CNTW, 32, width of cycle and instruction counters
- TIMEOUT, 1000, watchdog limit in RUN cycles; 0 disables the watchdog

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin monitoring (effective in IDLE only)
- clear  in  1  abort/restart: return to IDLE, zero all counters and captures
- ir_valid  in  1  one-cycle strobe: ir holds a newly fetched instruction
- ir  in  MAXWIDTH  core instruction register
- pc  in  MAXWIDTH  core program counter (address of the fetched instruction when ir_valid)
- acc  in  MAXWIDTH  core accumulator
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- timeout  out  1  state == TIMEOUT
- done  out  1  halted | timeout
- cycles  out  CNTW  clocks spent in RUN
- instrs  out  CNTW  ir_valid strobes accepted in RUN (including the STP)
- halt_pc  out  MAXWIDTH  pc captured at STP fetch
- halt_acc  out  MAXWIDTH  acc captured at STP fetch

## Operation
- States: IDLE, RUN, HALTED, TIMEOUT; all outputs are registered.
- Reset (reset == 0 at an edge): state IDLE; cycles, instrs, halt_pc, halt_acc = 0; all flags 0. Reset overrides every input, including mid-run.
- Priority at each edge: reset > clear > state logic.
- clear in any state: go to IDLE and zero counters/captures; start in the same cycle is ignored.
- IDLE: start = 1 -> RUN; counters stay 0. ir_valid is ignored.
- RUN, every edge: cycles <= cycles + 1, saturating at 2^CNTW-1. If ir_valid is set, instrs <= instrs + 1, also saturating.
- RUN, STP detection: ir_valid = 1 and opcode == STP -> HALTED; halt_pc <= pc, halt_acc <= acc. The STP cycle is counted in both cycles and instrs.
- RUN, watchdog: TIMEOUT != 0, cycles == TIMEOUT-1 before the edge and no STP detected -> TIMEOUT, with cycles == TIMEOUT afterwards. The watchdog is never armed when TIMEOUT == 0.
- Simultaneous STP and watchdog expiry on the same edge: HALTED wins.
- HALTED, TIMEOUT: terminal; all counters and captures are frozen, start and ir_valid are ignored, and the state is left only via clear or reset.
- An opcode equal to STP without ir_valid is not a halt (ir may be mid-update).

## Timing
- Latency: the flag rises on the edge that samples the qualifying condition. The registered output is visible in the following cycle.
- start at edge k -> running = 1 after edge k, and cycles = 1 after edge k+1.
- STP sampled at edge k -> halted = 1, done = 1, running = 0 after edge k. halt_pc and halt_acc are valid in the same cycle.
- cycles and instrs are updated on the same edge as the state transition.
- done is combinational OR of two registers with no extra delay.

## Test plan
- Reset: drive reset = 0 for 2 cycles with start = 1 and ir_valid toggling -> state IDLE, all outputs 0. Then reset = 1 with no start -> still IDLE after 10 cycles.
- Normal halt: start, then 5 ir_valid strobes with opcodes 0,1,2,3,STP at pc = 0..4 and acc = 16'h00AB on the STP, one strobe every 3 cycles (the fifth strobe at the 13th RUN edge) -> halted = 1, instrs = 5, cycles = 13, halt_pc = 4, halt_acc = 16'h00AB, then frozen for 20 cycles.
- Watchdog: TIMEOUT = 50, start, no STP -> timeout = 1 after the 50th RUN edge, cycles = 50, halted = 0. With TIMEOUT = 0 and no STP for 2000 cycles -> running stays 1.
- Collision: TIMEOUT = 50, STP strobe on the 50th RUN edge -> halted = 1, timeout = 0, cycles = 50.
- Clear mid-run and restart: clear after 7 RUN cycles, together with start -> IDLE, counters 0. Start next cycle -> cycles restarts from 1. An STP-valued ir without ir_valid does not halt.
- Saturation: CNTW = 4, TIMEOUT = 0, run 20 cycles with ir_valid held at 1 and a non-STP opcode -> cycles = 15, instrs = 15, no wrap.

Source files
------------

// File: rtl/mu0_run_monitor.sv
// Run-control and halt monitor for an MU0 core: detects STP fetch or watchdog expiry,
// counts RUN cycles and accepted instructions, and captures PC/ACC at halt.
module mu0_run_monitor #(
    parameter int               MAXWIDTH = 16,
    parameter int               OPW      = 4,
    parameter logic [OPW-1:0]   STP      = 4'b0111,
    parameter int               CNTW     = 32,
    parameter int               TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic                ir_valid,
    input  logic [MAXWIDTH-1:0] ir,
    input  logic [MAXWIDTH-1:0] pc,
    input  logic [MAXWIDTH-1:0] acc,
    output logic                running,
    output logic                halted,
    output logic                timeout,
    output logic                done,
    output logic [CNTW-1:0]     cycles,
    output logic [CNTW-1:0]     instrs,
    output logic [MAXWIDTH-1:0] halt_pc,
    output logic [MAXWIDTH-1:0] halt_acc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    // Watchdog compare is done in 64 bits so any TIMEOUT/CNTW pairing is legal.
    localparam bit          WD_EN = (TIMEOUT != 0);
    localparam logic [63:0] TO_M1 = (TIMEOUT == 0) ? 64'd0 : 64'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cycles_q, cycles_d;
    logic [CNTW-1:0]       instrs_q, instrs_d;
    logic [MAXWIDTH-1:0]   halt_pc_q, halt_pc_d;
    logic [MAXWIDTH-1:0]   halt_acc_q, halt_acc_d;
    logic                  running_q, halted_q, timeout_q;
    logic                  stp_s, wd_s, unused_ir_s;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (v == {CNTW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNTW-1){1'b0}}, 1'b1};
        end
    endfunction

    assign stp_s       = ir_valid && (ir[MAXWIDTH-1 -: OPW] == STP);
    assign wd_s        = WD_EN && ({{(64-CNTW){1'b0}}, cycles_q} == TO_M1);
    assign unused_ir_s = ^ir[MAXWIDTH-OPW-1:0];

    // Next-state, counter and capture logic; clear dominates the state machine.
    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        instrs_d   = instrs_q;
        halt_pc_d  = halt_pc_q;
        halt_acc_d = halt_acc_q;
        if (clear) begin
            state_d    = S_IDLE;
            cycles_d   = {CNTW{1'b0}};
            instrs_d   = {CNTW{1'b0}};
            halt_pc_d  = {MAXWIDTH{1'b0}};
            halt_acc_d = {MAXWIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    cycles_d = sat_inc(cycles_q);
                    if (ir_valid) begin
                        instrs_d = sat_inc(instrs_q);
                    end else begin
                        instrs_d = instrs_q;
                    end
                    // STP beats a watchdog expiry landing on the same edge.
                    if (stp_s) begin
                        state_d    = S_HALTED;
                        halt_pc_d  = pc;
                        halt_acc_d = acc;
                    end else if (wd_s) begin
                        state_d = S_TIMEOUT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_HALTED:  state_d = S_HALTED;
                S_TIMEOUT: state_d = S_TIMEOUT;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // State, counters, captures and decoded status flags, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cycles_q   <= {CNTW{1'b0}};
            instrs_q   <= {CNTW{1'b0}};
            halt_pc_q  <= {MAXWIDTH{1'b0}};
            halt_acc_q <= {MAXWIDTH{1'b0}};
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            instrs_q   <= instrs_d;
            halt_pc_q  <= halt_pc_d;
            halt_acc_q <= halt_acc_d;
            running_q  <= (state_d == S_RUN);
            halted_q   <= (state_d == S_HALTED);
            timeout_q  <= (state_d == S_TIMEOUT);
        end
    end

    assign running  = running_q;
    assign halted   = halted_q;
    assign timeout  = timeout_q;
    assign done     = halted_q | timeout_q;
    assign cycles   = cycles_q;
    assign instrs   = instrs_q;
    assign halt_pc  = halt_pc_q;
    assign halt_acc = halt_acc_q;

endmodule
